// File: rtl/mem_line_xfer.sv
// mem_line_xfer
// Line-transfer engine between the data cache and word-wide data memory.
// One cache request becomes a sequence of single-word memory beats: an
// optional writeback of the victim line, then an optional fill of the
// requested line. The assembled fill line is returned with a one-cycle ack.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req                 request strobe (sampled in IDLE only)
//   wb_en, fill_en      phases requested
//   wb_addr, fill_addr  line addresses (offset bits ignored)
//   wb_line             victim data, word i at [32i+31:32i]
//   fill_line           assembled fill data, same packing
//   busy, ack           engine status / completion pulse
//   HSEL, we, re, a, wd memory request (all registered)
//   rd, Valid           memory response
module mem_line_xfer #(
    parameter int WORDS       = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  wb_en,
    input  logic                  fill_en,
    input  logic [31:0]           wb_addr,
    input  logic [31:0]           fill_addr,
    input  logic [32*WORDS-1:0]   wb_line,
    output logic [32*WORDS-1:0]   fill_line,
    output logic                  busy,
    output logic                  ack,
    output logic                  HSEL,
    output logic                  we,
    output logic                  re,
    output logic [31:0]           a,
    output logic [31:0]           wd,
    input  logic [31:0]           rd,
    input  logic                  Valid
);

    localparam int BW  = $clog2(WORDS);
    localparam int OFF = BW + 2;
    localparam int WW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [31:OFF]         wb_base_q, wb_base_d;
    logic [31:OFF]         fill_base_q, fill_base_d;
    logic                  fill_en_q, fill_en_d;
    logic [32*WORDS-1:0]   wb_buf_q, wb_buf_d;
    logic [32*WORDS-1:0]   fill_line_q, fill_line_d;
    logic                  hsel_q, hsel_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic [31:0]           a_q, a_d;
    logic [31:0]           wd_q, wd_d;
    logic                  ack_q, ack_d;

    logic [BW-1:0]         beat_nxt;
    logic                  beat_done;

    // Line-offset bits of the request addresses are intentionally dropped.
    logic unused_offsets;
    assign unused_offsets = ^{wb_addr[OFF-1:0], fill_addr[OFF-1:0]};

    assign beat_nxt  = beat_q + 1'b1;
    // A beat finishes only after its full wait count and with memory Valid;
    // otherwise it is held with the wait counter saturated.
    assign beat_done = (wait_q == WAIT_MAX) && Valid;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        wb_base_d   = wb_base_q;
        fill_base_d = fill_base_q;
        fill_en_d   = fill_en_q;
        wb_buf_d    = wb_buf_q;
        fill_line_d = fill_line_q;
        hsel_d      = hsel_q;
        we_d        = we_q;
        re_d        = re_q;
        a_d         = a_q;
        wd_d        = wd_q;
        ack_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    wb_base_d   = wb_addr[31:OFF];
                    fill_base_d = fill_addr[31:OFF];
                    wb_buf_d    = wb_line;
                    fill_en_d   = fill_en;
                    beat_d      = '0;
                    wait_d      = '0;
                    // Outputs are registered, so beat 0 is set up here to
                    // appear on the bus in the first busy cycle.
                    if (wb_en) begin
                        state_d = WB;
                        hsel_d  = 1'b1;
                        we_d    = 1'b1;
                        re_d    = 1'b0;
                        a_d     = {wb_addr[31:OFF], {BW{1'b0}}, 2'b00};
                        wd_d    = wb_line[31:0];
                    end else if (fill_en) begin
                        state_d = FILL;
                        hsel_d  = 1'b1;
                        we_d    = 1'b0;
                        re_d    = 1'b1;
                        a_d     = {fill_addr[31:OFF], {BW{1'b0}}, 2'b00};
                        wd_d    = '0;
                    end else begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                    end
                end
            end

            WB: begin
                if (beat_done) begin
                    wait_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (fill_en_q) begin
                            state_d = FILL;
                            hsel_d  = 1'b1;
                            we_d    = 1'b0;
                            re_d    = 1'b1;
                            a_d     = {fill_base_q, {BW{1'b0}}, 2'b00};
                            wd_d    = '0;
                        end else begin
                            state_d = DONE;
                            hsel_d  = 1'b0;
                            we_d    = 1'b0;
                            re_d    = 1'b0;
                            a_d     = '0;
                            wd_d    = '0;
                            ack_d   = 1'b1;
                        end
                    end else begin
                        beat_d = beat_nxt;
                        a_d    = {wb_base_q, beat_nxt, 2'b00};
                        wd_d   = wb_buf_q[32*int'(beat_nxt) +: 32];
                    end
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
            end

            FILL: begin
                if (beat_done) begin
                    wait_d = '0;
                    fill_line_d[32*int'(beat_q) +: 32] = rd;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = DONE;
                        hsel_d  = 1'b0;
                        we_d    = 1'b0;
                        re_d    = 1'b0;
                        a_d     = '0;
                        wd_d    = '0;
                        ack_d   = 1'b1;
                    end else begin
                        beat_d = beat_nxt;
                        a_d    = {fill_base_q, beat_nxt, 2'b00};
                    end
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                hsel_d  = 1'b0;
                we_d    = 1'b0;
                re_d    = 1'b0;
                a_d     = '0;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            wb_base_q   <= '0;
            fill_base_q <= '0;
            fill_en_q   <= 1'b0;
            wb_buf_q    <= '0;
            fill_line_q <= '0;
            hsel_q      <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            a_q         <= '0;
            wd_q        <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            wb_base_q   <= wb_base_d;
            fill_base_q <= fill_base_d;
            fill_en_q   <= fill_en_d;
            wb_buf_q    <= wb_buf_d;
            fill_line_q <= fill_line_d;
            hsel_q      <= hsel_d;
            we_q        <= we_d;
            re_q        <= re_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            ack_q       <= ack_d;
        end
    end

    assign fill_line = fill_line_q;
    assign busy      = (state_q != IDLE);
    assign ack       = ack_q;
    assign HSEL      = hsel_q;
    assign we        = we_q;
    assign re        = re_q;
    assign a         = a_q;
    assign wd        = wd_q;

endmodule

// File: tb/tb_mem_line_xfer.sv
// Bench for mem_line_xfer: two instances (no wait states / two wait states),
// each with its own word memory, reference model and scoreboard monitor.
module tb_mem_line_xfer;

    localparam int WORDS = 4;
    localparam int LW    = 32 * WORDS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic        re;
        logic [31:0] wd;
    } beat_t;

    typedef struct {
        int            acc;
        int            lat;
        logic [LW-1:0] fill;
    } resp_t;

    task automatic chk(input int ln, input string nm,
                       input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s got=%h want=%h", ln, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int WS = (g == 0) ? 0 : 2;

        logic          rst_n = 1'b0;
        logic          req = 1'b0, wb_en = 1'b0, fill_en = 1'b0;
        logic [31:0]   wb_addr = '0, fill_addr = '0;
        logic [LW-1:0] wb_line = '0;
        logic [LW-1:0] fill_line;
        logic          busy, ack, hsel, we, re;
        logic [31:0]   a, wd, rd;
        logic          valid = 1'b1;

        logic [31:0]   mem  [1024];
        logic [31:0]   refm [1024];
        logic [LW-1:0] last_fill = '0;
        beat_t         bq[$];
        resp_t         eq[$];
        int            ack_cnt = 0, last_ack = 0, hold = 0, stalls = 0;
        int            vmode = 0, vlo = 0, vhi = -1;
        bit            done = 1'b0;

        mem_line_xfer #(.WORDS(WORDS), .WAIT_STATES(WS)) dut (
            .clk(clk), .reset(rst_n), .req(req), .wb_en(wb_en),
            .fill_en(fill_en), .wb_addr(wb_addr), .fill_addr(fill_addr),
            .wb_line(wb_line), .fill_line(fill_line), .busy(busy), .ack(ack),
            .HSEL(hsel), .we(we), .re(re), .a(a), .wd(wd), .rd(rd),
            .Valid(valid)
        );

        assign rd = mem[a[11:2]];

        // Word memory: word at byte address 4*i starts as i+0x60 (so
        // 0x100..0x10C hold 0xA0..0xA3); accepts writes whenever Valid.
        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'(i) + 32'h60;
            forever begin
                @(posedge clk);
                if (hsel && we && valid) mem[a[11:2]] = wd;
            end
        end

        always @(posedge clk) begin
            #1;
            case (vmode)
                0:       valid = 1'b1;
                1:       valid = ($urandom_range(0, 3) != 0);
                default: valid = !(cyc >= vlo && cyc <= vhi);
            endcase
        end

        // Scoreboard monitor.
        resp_t e;
        always @(negedge clk) begin
            if (!rst_n) begin
                bq.delete();
                eq.delete();
                hold   = 0;
                stalls = 0;
            end else begin
                if (hsel) begin
                    if (bq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lane%0d unexpected_beat a=%h cyc=%0d", g, a, cyc);
                    end else begin
                        chk(g, "beat", LW'({a, we, re, wd}),
                            LW'({bq[0].a, bq[0].we, bq[0].re, bq[0].wd}));
                        hold++;
                        if (hold >= WS + 1) begin
                            if (valid) begin
                                void'(bq.pop_front());
                                hold = 0;
                            end else begin
                                stalls++;
                            end
                        end
                    end
                end else if (we || re) begin
                    checks++;
                    errors++;
                    $display("FAIL lane%0d enable_without_hsel we=%b re=%b", g, we, re);
                end
                if (ack) begin
                    if (eq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lane%0d unexpected_ack cyc=%0d", g, cyc);
                    end else begin
                        e = eq.pop_front();
                        chk(g, "ack_latency", LW'(cyc - e.acc), LW'(e.lat + stalls));
                        chk(g, "fill_line", fill_line, e.fill);
                        chk(g, "busy_at_ack", LW'(busy), LW'(1));
                        chk(g, "beats_left", LW'(bq.size()), LW'(0));
                    end
                    stalls   = 0;
                    ack_cnt++;
                    last_ack = cyc;
                end
            end
        end

        // Reference model: writeback lands in memory first, then the fill
        // reads the line; latency from the phase count.
        task automatic model(input logic w, input logic f, input logic [31:0] wa,
                             input logic [31:0] fa, input logic [LW-1:0] wl,
                             input int acc);
            logic [31:0] wbase, fbase;
            int ph;
            resp_t r;
            wbase = wa & ~32'(4 * WORDS - 1);
            fbase = fa & ~32'(4 * WORDS - 1);
            ph = 0;
            if (w) begin
                ph++;
                for (int i = 0; i < WORDS; i++) begin
                    bq.push_back('{wbase + 32'(4 * i), 1'b1, 1'b0, wl[32*i +: 32]});
                    refm[int'(wbase[11:2]) + i] = wl[32*i +: 32];
                end
            end
            if (f) begin
                ph++;
                for (int i = 0; i < WORDS; i++) begin
                    bq.push_back('{fbase + 32'(4 * i), 1'b0, 1'b1, 32'h0});
                    last_fill[32*i +: 32] = refm[int'(fbase[11:2]) + i];
                end
            end
            r.acc  = acc;
            r.lat  = 1 + WORDS * (WS + 1) * ph;
            r.fill = last_fill;
            eq.push_back(r);
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            @(posedge clk); #1;
            while (busy && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (busy) begin
                checks++;
                errors++;
                $display("FAIL lane%0d idle_timeout busy=%b", g, busy);
            end
        endtask

        task automatic issue(input logic w, input logic f, input logic [31:0] wa,
                             input logic [31:0] fa, input logic [LW-1:0] wl,
                             output int acc);
            wait_idle();
            wb_en = w; fill_en = f; wb_addr = wa; fill_addr = fa; wb_line = wl;
            req = 1'b1;
            acc = cyc;
            model(w, f, wa, fa, wl, acc);
            @(posedge clk); #1;
            req       = 1'b0;
            wb_en     = 1'($urandom);
            fill_en   = 1'($urandom);
            wb_addr   = $urandom;
            fill_addr = $urandom;
            wb_line   = {$urandom, $urandom, $urandom, $urandom};
        endtask

        task automatic wait_acks(input int n);
            int t;
            t = 0;
            while (ack_cnt < n && t < 400) begin
                @(posedge clk);
                t++;
            end
            if (ack_cnt < n) begin
                checks++;
                errors++;
                $display("FAIL lane%0d ack_timeout got=%0d want=%0d", g, ack_cnt, n);
            end
        endtask

        task automatic random_reqs(input int n);
            int acc, base;
            for (int k = 0; k < n; k++) begin
                base = ack_cnt;
                issue(1'($urandom), 1'($urandom), $urandom & 32'hFFF,
                      $urandom & 32'hFFF, {$urandom, $urandom, $urandom, $urandom}, acc);
                wait_acks(base + 1);
            end
        endtask

        initial begin
            for (int i = 0; i < 1024; i++) refm[i] = 32'(i) + 32'h60;
        end

        if (g == 0) begin : directed
            initial begin
                int acc, n0;
                #12;
                chk(g, "reset_outputs", LW'({busy, ack, hsel, we, re, a, wd}), LW'(0));
                chk(g, "reset_fill_line", fill_line, LW'(0));
                @(negedge clk); rst_n = 1'b1;

                // fill only
                issue(1'b0, 1'b1, 32'h0, 32'h104, '0, acc);
                wait_acks(1);
                chk(g, "fill_ack_T5", LW'(last_ack - acc), LW'(5));
                chk(g, "fill_line_A", fill_line,
                    {32'hA3, 32'hA2, 32'hA1, 32'hA0});

                // writeback + fill
                issue(1'b1, 1'b1, 32'h200, 32'h300,
                      {32'd4, 32'd3, 32'd2, 32'd1}, acc);
                wait_acks(2);
                chk(g, "wbfill_ack_T9", LW'(last_ack - acc), LW'(9));
                chk(g, "wb_mem", LW'({mem[131], mem[130], mem[129], mem[128]}),
                    {32'd4, 32'd3, 32'd2, 32'd1});

                // neither phase
                issue(1'b0, 1'b0, 32'h40, 32'h80, '0, acc);
                wait_acks(3);
                chk(g, "none_ack_T1", LW'(last_ack - acc), LW'(1));

                // req pulsed while busy is ignored
                issue(1'b0, 1'b1, 32'h0, 32'h3C0, '0, acc);
                @(posedge clk); #1; req = 1'b1; wb_en = 1'b1; fill_en = 1'b1;
                @(posedge clk); #1; req = 1'b0;
                wait_acks(4);
                repeat (10) @(posedge clk);
                chk(g, "no_extra_ack", LW'(ack_cnt), LW'(4));

                // req held high is re-accepted right after ack
                wait_idle();
                wb_en = 1'b0; fill_en = 1'b0; req = 1'b1;
                acc = cyc;
                model(1'b0, 1'b0, 32'h0, 32'h0, '0, acc);
                model(1'b0, 1'b0, 32'h0, 32'h0, '0, acc + 2);
                @(posedge clk); #1;
                @(posedge clk); #1;
                @(posedge clk); #1; req = 1'b0;
                wait_acks(6);
                chk(g, "held_req_ack", LW'(last_ack - acc), LW'(3));

                // reset during beat 2 of a fill
                issue(1'b0, 1'b1, 32'h0, 32'h500, '0, acc);
                @(posedge clk); #1;
                @(posedge clk); #1;
                #2 rst_n = 1'b0;
                #1;
                chk(g, "midreset_outputs", LW'({busy, ack, hsel, we, re, a, wd}), LW'(0));
                chk(g, "midreset_fill_line", fill_line, LW'(0));
                last_fill = '0;
                n0 = ack_cnt;
                @(posedge clk); #1; rst_n = 1'b1;
                repeat (8) @(posedge clk);
                chk(g, "no_ack_after_reset", LW'(ack_cnt), LW'(n0));
                issue(1'b0, 1'b1, 32'h0, 32'h104, '0, acc);
                wait_acks(n0 + 1);
                chk(g, "post_reset_fill", fill_line,
                    {32'hA3, 32'hA2, 32'hA1, 32'hA0});

                vmode = 1;
                random_reqs(40);
                done = 1'b1;
            end
        end else begin : stalled
            initial begin
                int acc;
                #12;
                chk(g, "reset_outputs", LW'({busy, ack, hsel, we, re, a, wd}), LW'(0));
                @(negedge clk); rst_n = 1'b1;

                // two wait states, Valid low for 3 extra cycles on beat 1
                vmode = 2;
                issue(1'b0, 1'b1, 32'h0, 32'h100, '0, acc);
                vlo = acc + 6;
                vhi = acc + 8;
                wait_acks(1);
                chk(g, "stall_ack_T16", LW'(last_ack - acc), LW'(16));
                chk(g, "stall_fill_line", fill_line,
                    {32'hA3, 32'hA2, 32'hA1, 32'hA0});

                issue(1'b1, 1'b1, 32'h600, 32'h600,
                      {32'h44, 32'h33, 32'h22, 32'h11}, acc);
                wait_acks(2);
                chk(g, "ws_wbfill_ack", LW'(last_ack - acc), LW'(25));

                vmode = 1;
                random_reqs(40);
                done = 1'b1;
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(lane[0].done && lane[1].done) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (!(lane[0].done && lane[1].done)) begin
            checks++;
            errors++;
            $display("FAIL global_timeout lane0=%b lane1=%b", lane[0].done, lane[1].done);
        end
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
